// File: rtl/computation_controller.sv
// computation_controller
//   Sequences jobs on an external computation_module: a STORE phase followed
//   by one or three compute runs (single, sa3, sa2), each preceded by a
//   one-cycle all-idle GAP. Captures each run's 2x2 result, pulses res_valid,
//   and for the three-run job reports whether all results agreed. A 6-bit
//   watchdog aborts a phase whose done never arrives.
// Ports
//   clk, rst (async, active-low)
//   start, mode[1:0]             job request / select (00 single, 01 sa3, 10 sa2, 11 all)
//   done_store/single/sa3/sa2    completion flags from computation_module
//   c11..c22[7:0]                computation_module result
//   active_store/single/sa3/sa2  one-hot phase requests (registered)
//   busy, res_valid, res_mode[1:0], r11..r22[7:0], match, err
module computation_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       done_store,
    input  logic       done_single,
    input  logic       done_sa3,
    input  logic       done_sa2,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    output logic       active_store,
    output logic       active_single,
    output logic       active_sa3,
    output logic       active_sa2,
    output logic       busy,
    output logic       res_valid,
    output logic [1:0] res_mode,
    output logic [7:0] r11,
    output logic [7:0] r12,
    output logic [7:0] r21,
    output logic [7:0] r22,
    output logic       match,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, STORE, GAP, RUN, FINISH} state_t;

    state_t     state, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] idx, idx_d;          // run index within a mode-11 job
    logic [5:0] wd, wd_d;
    logic [3:0] act, act_d;          // {sa2, sa3, single, store}
    logic       busy_d, res_valid_d, match_d, err_d, acc, acc_d;
    logic [1:0] res_mode_d;
    logic [7:0] r11_d, r12_d, r21_d, r22_d;
    logic [1:0] cur;
    logic [3:0] done_vec;
    logic       done_cur, same, first;

    // Run encoding equals res_mode: 00 single, 01 sa3, 10 sa2.
    function automatic logic [3:0] run_req(input logic [1:0] m);
        return 4'b0010 << m;
    endfunction

    assign cur      = (mode_q == 2'b11) ? idx : mode_q;
    assign done_vec = {done_sa2, done_sa3, done_single, done_store};
    // Only the done of the phase currently requested counts.
    assign done_cur = |(done_vec & act & run_req(cur));
    assign same     = (c11 == r11) && (c12 == r12) && (c21 == r21) && (c22 == r22);
    assign first    = (mode_q != 2'b11) || (idx == 2'd0);

    assign {active_sa2, active_sa3, active_single, active_store} = act;

    always_comb begin
        state_d     = state;
        mode_d      = mode_q;
        idx_d       = idx;
        wd_d        = wd;
        act_d       = '0;
        res_valid_d = 1'b0;
        res_mode_d  = res_mode;
        match_d     = match;
        err_d       = err;
        acc_d       = acc;
        r11_d       = r11;
        r12_d       = r12;
        r21_d       = r21;
        r22_d       = r22;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = STORE;
                    mode_d  = mode;
                    idx_d   = '0;
                    wd_d    = '0;
                    err_d   = 1'b0;
                    match_d = 1'b0;
                    act_d   = 4'b0001;
                end
            end
            STORE: begin
                if (done_store && act[0]) begin
                    state_d = GAP;
                end else if (wd == 6'd62) begin
                    // 63rd active cycle without done: abort
                    state_d = IDLE;
                    wd_d    = 6'd63;
                    err_d   = 1'b1;
                end else begin
                    wd_d  = wd + 6'd1;
                    act_d = 4'b0001;
                end
            end
            GAP: begin
                state_d = RUN;
                wd_d    = '0;
                act_d   = run_req(cur);
            end
            RUN: begin
                if (done_cur) begin
                    r11_d       = c11;
                    r12_d       = c12;
                    r21_d       = c21;
                    r22_d       = c22;
                    res_mode_d  = cur;
                    res_valid_d = 1'b1;
                    // Chained compare against the previous capture implies
                    // element-wise equality of all three results.
                    acc_d       = first ? 1'b1 : (acc & same);
                    if ((mode_q == 2'b11) && (idx != 2'd2)) begin
                        idx_d   = idx + 2'd1;
                        state_d = GAP;
                    end else begin
                        state_d = FINISH;
                        match_d = acc_d;
                    end
                end else if (wd == 6'd62) begin
                    state_d = IDLE;
                    wd_d    = 6'd63;
                    err_d   = 1'b1;
                end else begin
                    wd_d  = wd + 6'd1;
                    act_d = run_req(cur);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= '0;
            idx       <= '0;
            wd        <= '0;
            act       <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_mode  <= '0;
            match     <= 1'b0;
            err       <= 1'b0;
            acc       <= 1'b0;
            r11       <= '0;
            r12       <= '0;
            r21       <= '0;
            r22       <= '0;
        end else begin
            state     <= state_d;
            mode_q    <= mode_d;
            idx       <= idx_d;
            wd        <= wd_d;
            act       <= act_d;
            busy      <= busy_d;
            res_valid <= res_valid_d;
            res_mode  <= res_mode_d;
            match     <= match_d;
            err       <= err_d;
            acc       <= acc_d;
            r11       <= r11_d;
            r12       <= r12_d;
            r21       <= r21_d;
            r22       <= r22_d;
        end
    end

endmodule

// File: tb/tb_computation_controller.sv
// Directed bench for computation_controller with a responder stub that
// raises done_X three cycles after active_X rises.
module tb_computation_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       done_store, done_single, done_sa3, done_sa2;
    logic [7:0] c11, c12, c21, c22;
    logic       active_store, active_single, active_sa3, active_sa2;
    logic       busy, res_valid, match, err;
    logic [1:0] res_mode;
    logic [7:0] r11, r12, r21, r22;

    logic [3:0] en = 4'b1111;       // stub responds per phase {sa2,sa3,single,store}
    logic       stray_single = 1'b0;
    logic [7:0] c22_sa2 = 8'd54;
    int         cnt [4];
    int         n_vec = 0;
    int         n_err = 0;

    localparam logic [3:0] A_IDLE = 4'b0000, A_STORE = 4'b0001, A_SINGLE = 4'b0010,
                           A_SA3 = 4'b0100, A_SA2 = 4'b1000;

    computation_controller dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .done_store(done_store), .done_single(done_single),
        .done_sa3(done_sa3), .done_sa2(done_sa2),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .active_store(active_store), .active_single(active_single),
        .active_sa3(active_sa3), .active_sa2(active_sa2),
        .busy(busy), .res_valid(res_valid), .res_mode(res_mode),
        .r11(r11), .r12(r12), .r21(r21), .r22(r22),
        .match(match), .err(err)
    );

    always #5 clk = ~clk;

    logic [3:0] act;
    assign act = {active_sa2, active_sa3, active_single, active_store};

    // Stub: cnt[i] = cycles active[i] has been high; done on the 4th cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            cnt[i] <= act[i] ? ((cnt[i] < 100) ? cnt[i] + 1 : cnt[i]) : 0;
    end

    always_comb begin
        done_store  = act[0] && (cnt[0] == 3) && en[0];
        done_single = (act[1] && (cnt[1] == 3) && en[1]) || stray_single;
        done_sa3    = act[2] && (cnt[2] == 3) && en[2];
        done_sa2    = act[3] && (cnt[3] == 3) && en[3];
        c11 = 8'd36;
        c12 = 8'd54;
        c21 = 8'd36;
        c22 = active_sa2 ? c22_sa2 : 8'd54;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n cycles with the given active pattern, busy high, no result pulse
    task automatic exp_cyc(input string tag, input logic [3:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, " act"}, 32'(act), 32'(a));
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
        end
    endtask

    task automatic start_job(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        chk("start act", 32'(act), 32'(A_STORE));
        chk("start busy", 32'(busy), 32'd1);
        chk("start err", 32'(err), 32'd0);
        chk("start match", 32'(match), 32'd0);
    endtask

    // capture cycle: res_valid pulse with captured values
    task automatic cap(input string tag, input logic [1:0] m, input logic [7:0] e22,
                       input logic em);
        tick();
        chk({tag, " act"}, 32'(act), 32'(A_IDLE));
        chk({tag, " res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, " res_mode"}, 32'(res_mode), 32'(m));
        chk({tag, " r"}, {r11, r12, r21, r22}, {8'd36, 8'd54, 8'd36, e22});
        chk({tag, " match"}, 32'(match), 32'(em));
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic idle_chk(input string tag, input logic em);
        tick();
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, " act"}, 32'(act), 32'(A_IDLE));
        chk({tag, " match"}, 32'(match), 32'(em));
    endtask

    initial begin
        // reset state
        #1;
        chk("rst act", 32'(act), 32'(A_IDLE));
        chk("rst outs", {busy, res_valid, res_mode, match, err}, 32'd0);
        chk("rst r", {r11, r12, r21, r22}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("idle busy", 32'(busy), 32'd0);

        // mode 00
        start_job(2'b00);
        exp_cyc("m0 store", A_STORE, 3);
        exp_cyc("m0 gap", A_IDLE, 1);
        exp_cyc("m0 single", A_SINGLE, 4);
        cap("m0 fin", 2'b00, 8'd54, 1'b1);
        idle_chk("m0 idle", 1'b1);

        // mode 11, with a start/mode change while busy
        start_job(2'b11);
        start = 1'b1;
        mode  = 2'b01;
        exp_cyc("m3 store", A_STORE, 1);
        start = 1'b0;
        mode  = 2'b00;
        exp_cyc("m3 store", A_STORE, 2);
        exp_cyc("m3 gap0", A_IDLE, 1);
        exp_cyc("m3 single", A_SINGLE, 4);
        cap("m3 cap0", 2'b00, 8'd54, 1'b0);
        exp_cyc("m3 sa3", A_SA3, 4);
        cap("m3 cap1", 2'b01, 8'd54, 1'b0);
        exp_cyc("m3 sa2", A_SA2, 4);
        cap("m3 fin", 2'b10, 8'd54, 1'b1);
        idle_chk("m3 idle", 1'b1);
        tick();
        chk("m3 match hold", 32'(match), 32'd1);

        // mode 11 with differing sa2 result
        c22_sa2 = 8'd55;
        start_job(2'b11);
        exp_cyc("mm store", A_STORE, 3);
        exp_cyc("mm gap0", A_IDLE, 1);
        exp_cyc("mm single", A_SINGLE, 4);
        cap("mm cap0", 2'b00, 8'd54, 1'b0);
        exp_cyc("mm sa3", A_SA3, 4);
        cap("mm cap1", 2'b01, 8'd54, 1'b0);
        exp_cyc("mm sa2", A_SA2, 4);
        cap("mm fin", 2'b10, 8'd55, 1'b0);
        idle_chk("mm idle", 1'b0);
        c22_sa2 = 8'd54;

        // watchdog: sa3 never completes
        en[2] = 1'b0;
        start_job(2'b01);
        exp_cyc("wd store", A_STORE, 3);
        exp_cyc("wd gap", A_IDLE, 1);
        exp_cyc("wd sa3", A_SA3, 63);
        tick();
        chk("wd act", 32'(act), 32'(A_IDLE));
        chk("wd err", 32'(err), 32'd1);
        chk("wd busy", 32'(busy), 32'd0);
        chk("wd res_valid", 32'(res_valid), 32'd0);
        tick();
        chk("wd err sticky", 32'(err), 32'd1);
        chk("wd res_valid2", 32'(res_valid), 32'd0);
        chk("wd r held", {r11, r12, r21, r22}, {8'd36, 8'd54, 8'd36, 8'd55});
        en[2] = 1'b1;

        // reset during RUN
        start_job(2'b00);
        exp_cyc("rs store", A_STORE, 3);
        exp_cyc("rs gap", A_IDLE, 1);
        exp_cyc("rs single", A_SINGLE, 2);
        rst = 1'b0;
        #1;
        chk("rs act", 32'(act), 32'(A_IDLE));
        chk("rs outs", {busy, res_valid, res_mode, match, err}, 32'd0);
        chk("rs r", {r11, r12, r21, r22}, 32'd0);
        tick();
        chk("rs res_valid", 32'(res_valid), 32'd0);
        rst = 1'b1;
        tick();

        // normal job after reset, with a stray done_single during STORE
        start_job(2'b00);
        stray_single = 1'b1;
        exp_cyc("st store", A_STORE, 1);
        stray_single = 1'b0;
        exp_cyc("st store", A_STORE, 2);
        exp_cyc("st gap", A_IDLE, 1);
        exp_cyc("st single", A_SINGLE, 4);
        cap("st fin", 2'b00, 8'd54, 1'b1);
        idle_chk("st idle", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/computation_controller.md
COMPUTATION_CONTROLLER -- requirements
Module: computation_controller

Interface
REQ-001 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-002 SHALL have: start in 1 job request; mode in 2 job select (00 single, 01 sa3, 10 sa2, 11 all three in sequence).
REQ-003 SHALL have: done_store, done_single, done_sa3, done_sa2 in 1 each; completion flags from computation_module.
REQ-004 SHALL have: c11, c12, c21, c22 in 8 each; computation_module 2x2 result.
REQ-005 SHALL have: active_store, active_single, active_sa3, active_sa2 out 1 each; phase requests to computation_module.
REQ-006 SHALL have: busy out 1; res_valid out 1; res_mode out 2; r11, r12, r21, r22 out 8 each; match out 1; err out 1.
REQ-007 SHALL NOT route the A/B matrix buses; upstream holds them stable while busy=1.

Function
REQ-008 SHALL use FSM states IDLE, STORE, GAP, RUN, FINISH.
REQ-009 IDLE: start=1 sampled -> latch mode, clear err, enter STORE; active_store=1 and busy=1 from the next cycle.
REQ-010 start while busy=1 SHALL be ignored.
REQ-011 Each active_X SHALL be registered, held high until done_X is sampled high, and drop low the cycle after.
REQ-012 STORE->GAP on done_store; GAP SHALL last exactly 1 cycle with all active_* low.
REQ-013 GAP->RUN raising the active_* of the current run mode; job order for mode 11: single, sa3, sa2.
REQ-014 On the edge where done_X=1 and active_X=1 in RUN, SHALL capture c11..c22 into r11..r22 and res_mode.
REQ-015 res_valid SHALL pulse high exactly one cycle, the cycle after capture; r*/res_mode hold until the next capture.
REQ-016 After a capture: more modes pending -> GAP; otherwise -> FINISH.
REQ-017 FINISH SHALL last 1 cycle, then IDLE; busy deasserts on entry to IDLE.
REQ-018 done_* for a phase not currently requested SHALL be ignored.
REQ-019 Mode 11: match=1 in FINISH and after iff all three captured results are equal element-wise; modes 00/01/10: match=1.
REQ-020 match SHALL hold until the next start.
REQ-021 SHALL implement a 6-bit watchdog, cleared on entry to STORE and RUN, incrementing each cycle an active_* is high.
REQ-022 Watchdog reaching 63 with the awaited done still low: drop all active_* next cycle, err=1 (sticky until next start), no res_valid, return to IDLE.
REQ-023 At most one active_* SHALL be high in any cycle.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE and set every output to 0, including r*, res_mode and match, and clear the watchdog and latched mode.
REQ-025 rst asserted mid-job SHALL abort the job with no res_valid; first start after release runs normally.

Verification
REQ-026 Responder stub asserts done_X 3 cycles after active_X rises, c = {36,54,36,54}; mode 00 start -> active_store 1, then 1 gap cycle, then active_single, res_valid once, r11..r22=36,54,36,54, res_mode=00, match=1.
REQ-027 Mode 11, same stub -> three res_valid pulses with res_mode 00,01,10, each run preceded by exactly one all-low gap cycle, match=1.
REQ-028 Mode 11, sa2 stub returns c22=55 -> match=0 after FINISH, r22=55.
REQ-029 Stub never asserts done_sa3 (mode 01) -> active_sa3 high 63 cycles, then low, err=1, busy=0, no res_valid.
REQ-030 rst pulsed low during RUN -> all outputs 0 immediately; stray done_single while active_store is high -> ignored.
REQ-031 start pulsed again while busy -> no effect on sequence or mode.
